// File: rtl/mult_operand_sequencer_pkg.sv
// Shared constants and state encoding for the multiplier operand sequencer.
// CHECK has a fixed code so the encoding does not depend on whether resampling is built in.
package mult_pkg;

    localparam int MULT_WIDTH   = 4;
    localparam int SETTLE_MIN   = 1;
    localparam int SETTLE_MAX   = 15;
    localparam int SETTLE_CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SETTLE = 2'b01,
        ST_CHECK  = 2'b10,
        ST_HOLD   = 2'b11
    } mult_state_e;

    function automatic bit settle_cycles_legal(input int n);
        return (n >= SETTLE_MIN) && (n <= SETTLE_MAX);
    endfunction

endpackage

// File: rtl/mult_operand_sequencer_if.sv
// Operand capture, array-multiplier link and result handshake of the operand sequencer.
// slave: the sequencer side; master: the requester/consumer driving start and ready.
interface mult_operand_sequencer_if
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
);
    logic                 start_i;
    logic [WIDTH-1:0]     a_i;
    logic [WIDTH-1:0]     b_i;
    logic                 busy_o;
    logic [WIDTH-1:0]     mul_a_o;
    logic [WIDTH-1:0]     mul_b_o;
    logic [2*WIDTH-1:0]   mul_p_i;
    logic [2*WIDTH-1:0]   result_o;
    logic                 out_valid_o;
    logic                 out_ready_i;
    logic                 err_o;

    modport slave (
        input  start_i, a_i, b_i, mul_p_i, out_ready_i,
        output busy_o, mul_a_o, mul_b_o, result_o, out_valid_o, err_o
    );

    modport master (
        output start_i, a_i, b_i, mul_p_i, out_ready_i,
        input  busy_o, mul_a_o, mul_b_o, result_o, out_valid_o, err_o
    );

endinterface

// File: rtl/mult_operand_sequencer.sv
// Holds operands on the array multiplier, samples the product SETTLE_CYCLES edges after start
// (one more with MULT_RESAMPLE_EN), and holds it under valid/ready until taken; start is ignored while busy.
module mult_operand_sequencer
    import mult_pkg::*;
#(
    parameter int WIDTH         = MULT_WIDTH,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    mult_operand_sequencer_if.slave   bus
);

    localparam logic [1:0] S_IDLE   = ST_IDLE;
    localparam logic [1:0] S_SETTLE = ST_SETTLE;
    localparam logic [1:0] S_CHECK  = ST_CHECK;
    localparam logic [1:0] S_HOLD   = ST_HOLD;

    localparam logic [SETTLE_CNT_W-1:0] CNT_INIT = SETTLE_CNT_W'(SETTLE_CYCLES - 1);

    if (!settle_cycles_legal(SETTLE_CYCLES)) begin : g_bad_settle
        $error("mult_operand_sequencer: SETTLE_CYCLES must lie in 1..15");
    end

    logic [1:0]              r_state;
    logic [SETTLE_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]        r_mul_a;
    logic [WIDTH-1:0]        r_mul_b;
    logic [2*WIDTH-1:0]      r_result;
    logic                    r_valid;
`ifdef MULT_RESAMPLE_EN
    logic [2*WIDTH-1:0]      r_sample;
    logic                    r_err;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_mul_a  <= '0;
            r_mul_b  <= '0;
            r_result <= '0;
            r_valid  <= 1'b0;
`ifdef MULT_RESAMPLE_EN
            r_sample <= '0;
            r_err    <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start_i) begin
                        r_mul_a <= bus.a_i;
                        r_mul_b <= bus.b_i;
                        r_cnt   <= CNT_INIT;
                        r_state <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
`ifdef MULT_RESAMPLE_EN
                        r_sample <= bus.mul_p_i;
                        r_state  <= S_CHECK;
`else
                        r_result <= bus.mul_p_i;
                        r_valid  <= 1'b1;
                        r_state  <= S_HOLD;
`endif
                    end
                end
`ifdef MULT_RESAMPLE_EN
                // A product still moving one cycle after settling flags an undersized SETTLE_CYCLES.
                S_CHECK: begin
                    r_result <= bus.mul_p_i;
                    r_valid  <= 1'b1;
                    if (bus.mul_p_i != r_sample) begin
                        r_err <= 1'b1;
                    end
                    r_state <= S_HOLD;
                end
`endif
                S_HOLD: begin
                    if (bus.out_ready_i) begin
                        r_valid <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy_o      = (r_state != S_IDLE);
    assign bus.mul_a_o     = r_mul_a;
    assign bus.mul_b_o     = r_mul_b;
    assign bus.result_o    = r_result;
    assign bus.out_valid_o = r_valid;
`ifdef MULT_RESAMPLE_EN
    assign bus.err_o       = r_err;
`else
    assign bus.err_o       = 1'b0;
`endif

endmodule

// File: tb/tb_mult_operand_sequencer.sv
// Directed and randomized bench for mult_operand_sequencer with a behavioural stand-in for the array multiplier.
module tb_mult_operand_sequencer;
    import mult_pkg::*;

    localparam int W  = 4;
    localparam int SC = 2;
`ifdef MULT_RESAMPLE_EN
    localparam int LAT = SC + 1;
`else
    localparam int LAT = SC;
`endif

    logic       clk = 1'b0;
    logic       rst;
    int         checks = 0;
    int         errors = 0;
    bit         glitch_en = 1'b0;
    logic [7:0] glitch_val = 8'h00;
    logic       exp_err = 1'b0;

    always #5 clk = ~clk;

    mult_operand_sequencer_if #(.WIDTH(W)) bus ();

    mult_operand_sequencer #(.WIDTH(W), .SETTLE_CYCLES(SC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.mul_p_i = glitch_en ? glitch_val
                                   : ({4'b0000, bus.mul_a_o} * {4'b0000, bus.mul_b_o});

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},   16'(bus.busy_o),      16'h0);
        check({tag, "_mul_a"},  16'(bus.mul_a_o),     16'h0);
        check({tag, "_mul_b"},  16'(bus.mul_b_o),     16'h0);
        check({tag, "_result"}, 16'(bus.result_o),    16'h0);
        check({tag, "_valid"},  16'(bus.out_valid_o), 16'h0);
        check({tag, "_err"},    16'(bus.err_o),       16'h0);
    endtask

    // One transaction checked against the cycle-level contract: busy for LAT edges, then a held result.
    task automatic do_mul(input logic [3:0] a, input logic [3:0] b, input int hold,
                          input bit ready_early, input bit start_held);
        logic [7:0] exp_p;
        exp_p = 8'(a) * 8'(b);
        check("idle_before", 16'(bus.busy_o), 16'h0);
        bus.start_i     = 1'b1;
        bus.a_i         = a;
        bus.b_i         = b;
        bus.out_ready_i = ready_early;
        tick();
        bus.start_i = start_held;
        for (int k = 0; k < LAT; k++) begin
            check("settle_busy",  16'(bus.busy_o),      16'h1);
            check("settle_valid", 16'(bus.out_valid_o), 16'h0);
            check("settle_mul_a", 16'(bus.mul_a_o),     16'(a));
            check("settle_mul_b", 16'(bus.mul_b_o),     16'(b));
            bus.a_i = 4'($urandom);
            bus.b_i = 4'($urandom);
            tick();
        end
        check("valid_rise", 16'(bus.out_valid_o), 16'h1);
        check("result",     16'(bus.result_o),    16'(exp_p));
        check("err",        16'(bus.err_o),       16'(exp_err));
        for (int h = 0; h < hold; h++) begin
            tick();
            check("hold_valid",  16'(bus.out_valid_o), 16'h1);
            check("hold_busy",   16'(bus.busy_o),      16'h1);
            check("hold_result", 16'(bus.result_o),    16'(exp_p));
            check("hold_mul_a",  16'(bus.mul_a_o),     16'(a));
        end
        bus.out_ready_i = 1'b1;
        tick();
        check("post_valid",  16'(bus.out_valid_o), 16'h0);
        check("post_busy",   16'(bus.busy_o),      16'h0);
        check("post_result", 16'(bus.result_o),    16'(exp_p));
        bus.out_ready_i = 1'b0;
        bus.start_i     = 1'b0;
    endtask

    initial begin
        logic [3:0] ra;
        logic [3:0] rb;
        bit         re;
        int         rh;
        rst             = 1'b1;
        bus.start_i     = 1'b0;
        bus.a_i         = '0;
        bus.b_i         = '0;
        bus.out_ready_i = 1'b0;
        #1;
        check_all_zero("reset");
        tick();
        tick();
        rst = 1'b0;

        do_mul(4'hF, 4'hF, 0, 1'b1, 1'b0);
        do_mul(4'h7, 4'h9, 10, 1'b0, 1'b0);
        do_mul(4'h0, 4'hA, 0, 1'b0, 1'b0);
        do_mul(4'h1, 4'hA, 0, 1'b0, 1'b0);

        do_mul(4'h3, 4'h4, 2, 1'b0, 1'b1);
        do_mul(4'h5, 4'h6, 0, 1'b0, 1'b1);
        do_mul(4'hC, 4'hD, 1, 1'b0, 1'b0);

        // Asynchronous reset landing between edges while SETTLE is in progress.
        bus.start_i = 1'b1;
        bus.a_i     = 4'h9;
        bus.b_i     = 4'hB;
        tick();
        bus.start_i = 1'b0;
        bus.a_i     = 4'h0;
        bus.b_i     = 4'h0;
        #2 rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        tick();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("after_rst_valid", 16'(bus.out_valid_o), 16'h0);
            check("after_rst_busy",  16'(bus.busy_o),      16'h0);
        end

        for (int i = 0; i < 24; i++) begin
            ra = 4'($urandom);
            rb = 4'($urandom);
            re = ($urandom_range(0, 3) == 0);
            rh = re ? 0 : int'($urandom_range(0, 3));
            do_mul(ra, rb, rh, re, 1'($urandom));
        end

`ifdef MULT_RESAMPLE_EN
        // Product moves from 10 to 11 one cycle after SETTLE ends.
        glitch_en       = 1'b1;
        glitch_val      = 8'h10;
        bus.start_i     = 1'b1;
        bus.a_i         = 4'h3;
        bus.b_i         = 4'h5;
        bus.out_ready_i = 1'b0;
        tick();
        bus.start_i = 1'b0;
        tick();
        tick();
        check("glitch_pre_valid", 16'(bus.out_valid_o), 16'h0);
        glitch_val = 8'h11;
        tick();
        check("glitch_valid",  16'(bus.out_valid_o), 16'h1);
        check("glitch_result", 16'(bus.result_o),    16'h11);
        check("glitch_err",    16'(bus.err_o),       16'h1);
        bus.out_ready_i = 1'b1;
        tick();
        bus.out_ready_i = 1'b0;
        glitch_en       = 1'b0;
        exp_err         = 1'b1;
        do_mul(4'h2, 4'h7, 1, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        check_all_zero("err_clear");
        tick();
        rst     = 1'b0;
        exp_err = 1'b0;
        do_mul(4'hE, 4'h3, 0, 1'b0, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
